neuron_argmax_display_feeder: RTL and testbench

NEURON_ARGMAX_DISPLAY_FEEDER -- requirements
Module: neuron_argmax_display_feeder

---
 rtl/neuron_argmax_display_feeder_pkg.sv | 26 ++
 rtl/neuron_score_argmax.sv | 109 ++++++++++
 rtl/neuron_argmax_display_feeder.sv | 108 ++++++++++
 tb/tb_neuron_argmax_display_feeder.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_argmax_display_feeder_pkg.sv
// Shared types and defaults for the argmax display feeder: accumulator state
// encoding, the frame-result payload and a width helper.
package neuron_argmax_display_feeder_pkg;

    localparam int unsigned DEF_NUM_CLASSES    = 10;
    localparam int unsigned DEF_SCORE_WIDTH    = 16;
    localparam int unsigned DEF_MIN_UPDATE_GAP = 32;
    localparam int unsigned LED_W              = 8;

    typedef enum logic {
        ACCUM   = 1'b0,
        DISCARD = 1'b1
    } acc_state_e;

    // Completed-frame result handed from the argmax tracker to the publisher
    typedef struct packed {
        logic             valid;
        logic [LED_W-1:0] value;
    } result_t;

    // Bits needed to count 0..n-1, never less than one
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/neuron_score_argmax.sv
// Frame accumulator: tracks the running argmax over one frame of scores and
// reports the display value combinationally on the beat that completes it.
module neuron_score_argmax
    import neuron_argmax_display_feeder_pkg::*;
#(
    parameter int unsigned NUM_CLASSES = DEF_NUM_CLASSES,
    parameter int unsigned SCORE_WIDTH = DEF_SCORE_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          score_valid_i,
    input  logic signed [SCORE_WIDTH-1:0] score_i,
    input  logic                          score_last_i,
    input  logic                          display_mode_i,
    output result_t                       result_c,
    output logic                          frame_error_o
);

    localparam int unsigned     IDX_W    = idx_width(NUM_CLASSES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    acc_state_e                    state_q, state_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic [IDX_W-1:0]              best_idx_q, best_idx_d;
    logic signed [SCORE_WIDTH-1:0] best_score_q, best_score_d;
    logic                          frame_error_q, frame_error_d;

    logic                          take_beat;
    logic [IDX_W-1:0]              win_idx;
    logic signed [SCORE_WIDTH-1:0] win_score;
    logic [LED_W-1:0]              win_sat;

    // Best-so-far including the current beat; strict compare keeps the lower index on ties
    always_comb begin
        take_beat = (idx_q == '0) || (score_i > best_score_q);
        win_idx   = take_beat ? idx_q : best_idx_q;
        win_score = take_beat ? score_i : best_score_q;
        if (win_score[SCORE_WIDTH-1]) begin
            win_sat = '0;
        end else if ($unsigned(win_score) > SCORE_WIDTH'(255)) begin
            win_sat = '1;
        end else begin
            win_sat = win_score[LED_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ACCUM;
            idx_q         <= '0;
            best_idx_q    <= '0;
            best_score_q  <= '0;
            frame_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            best_idx_q    <= best_idx_d;
            best_score_q  <= best_score_d;
            frame_error_q <= frame_error_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        best_idx_d    = best_idx_q;
        best_score_d  = best_score_q;
        frame_error_d = 1'b0;
        result_c      = '0;

        case (state_q)
            ACCUM: begin
                if (score_valid_i) begin
                    best_idx_d   = win_idx;
                    best_score_d = win_score;
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
                        if (score_last_i) begin
                            result_c.valid = 1'b1;
                            result_c.value = display_mode_i ? win_sat : LED_W'(win_idx);
                        end else begin
                            // Frame longer than NUM_CLASSES: drop the rest of it
                            frame_error_d = 1'b1;
                            state_d       = DISCARD;
                        end
                    end else if (score_last_i) begin
                        idx_d         = '0;
                        frame_error_d = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            DISCARD: begin
                if (score_valid_i && score_last_i) begin
                    state_d = ACCUM;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = ACCUM;
                idx_d   = '0;
            end
        endcase
    end

    assign frame_error_o = frame_error_q;

endmodule

// File: rtl/neuron_argmax_display_feeder.sv
// Argmax display feeder: finds the winning class per frame and publishes it to
// the 7-segment controller no more often than every MIN_UPDATE_GAP cycles.
module neuron_argmax_display_feeder
    import neuron_argmax_display_feeder_pkg::*;
#(
    parameter int unsigned NUM_CLASSES    = DEF_NUM_CLASSES,
    parameter int unsigned SCORE_WIDTH    = DEF_SCORE_WIDTH,
    parameter int unsigned MIN_UPDATE_GAP = DEF_MIN_UPDATE_GAP
) (
    input  logic                          CLK,
    input  logic                          RESET_N,
    input  logic                          SCORE_VALID,
    input  logic signed [SCORE_WIDTH-1:0] SCORE,
    input  logic                          SCORE_LAST,
    input  logic                          DISPLAY_MODE,
    output logic [LED_W-1:0]              LED_DISPLAY_VALUE,
    output logic                          GENERATE_START_PULSE,
    output logic                          RESULT_READY,
    output logic                          FRAME_ERROR,
    output logic                          OVERRUN
);

    localparam int unsigned     GAP_W   = idx_width(MIN_UPDATE_GAP + 1);
    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(MIN_UPDATE_GAP);

    result_t          frame_res;

    logic             pending_q, pending_d;
    logic [LED_W-1:0] pend_val_q, pend_val_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [GAP_W-1:0] gap_inc;
    logic             publish;
    logic [LED_W-1:0] led_q, led_d;
    logic             start_q, start_d;
    logic             ready_q, ready_d;
    logic             overrun_q, overrun_d;

    neuron_score_argmax #(
        .NUM_CLASSES (NUM_CLASSES),
        .SCORE_WIDTH (SCORE_WIDTH)
    ) u_argmax (
        .clk            (CLK),
        .rst_n          (RESET_N),
        .score_valid_i  (SCORE_VALID),
        .score_i        (SCORE),
        .score_last_i   (SCORE_LAST),
        .display_mode_i (DISPLAY_MODE),
        .result_c       (frame_res),
        .frame_error_o  (FRAME_ERROR)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pending_q  <= 1'b0;
            pend_val_q <= '0;
            gap_q      <= GAP_MAX;
            led_q      <= '0;
            start_q    <= 1'b0;
            ready_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            pend_val_q <= pend_val_d;
            gap_q      <= gap_d;
            led_q      <= led_d;
            start_q    <= start_d;
            ready_q    <= ready_d;
            overrun_q  <= overrun_d;
        end
    end

    // The gap test includes the cycle this edge closes, so updates land exactly
    // MIN_UPDATE_GAP cycles apart at the fastest.
    always_comb begin
        gap_inc    = (gap_q == GAP_MAX) ? gap_q : gap_q + GAP_W'(1);
        publish    = pending_q && (gap_inc == GAP_MAX);

        pending_d  = pending_q;
        pend_val_d = pend_val_q;
        gap_d      = gap_inc;
        led_d      = led_q;
        start_d    = start_q;
        ready_d    = 1'b0;
        overrun_d  = 1'b0;

        if (publish) begin
            led_d     = pend_val_q;
            start_d   = ~start_q;
            ready_d   = 1'b1;
            gap_d     = '0;
            pending_d = 1'b0;
        end

        // A new result always wins the pending slot; it only counts as an
        // overrun if the old one was not published on this same edge.
        if (frame_res.valid) begin
            pending_d  = 1'b1;
            pend_val_d = frame_res.value;
            overrun_d  = pending_q && !publish;
        end
    end

    assign LED_DISPLAY_VALUE    = led_q;
    assign GENERATE_START_PULSE = start_q;
    assign RESULT_READY         = ready_q;
    assign OVERRUN              = overrun_q;

endmodule

// File: tb/tb_neuron_argmax_display_feeder.sv
// Randomized and directed bench for neuron_argmax_display_feeder against a
// frame-level reference model (queue of beats, argmax by plain arithmetic).
module tb_neuron_argmax_display_feeder;

    localparam int N   = 10;
    localparam int SW  = 16;
    localparam int GAP = 32;

    logic                 CLK;
    logic                 RESET_N;
    logic                 SCORE_VALID;
    logic signed [SW-1:0] SCORE;
    logic                 SCORE_LAST;
    logic                 DISPLAY_MODE;
    logic [7:0]           LED_DISPLAY_VALUE;
    logic                 GENERATE_START_PULSE;
    logic                 RESULT_READY;
    logic                 FRAME_ERROR;
    logic                 OVERRUN;

    neuron_argmax_display_feeder #(
        .NUM_CLASSES    (N),
        .SCORE_WIDTH    (SW),
        .MIN_UPDATE_GAP (GAP)
    ) dut (
        .CLK                  (CLK),
        .RESET_N              (RESET_N),
        .SCORE_VALID          (SCORE_VALID),
        .SCORE                (SCORE),
        .SCORE_LAST           (SCORE_LAST),
        .DISPLAY_MODE         (DISPLAY_MODE),
        .LED_DISPLAY_VALUE    (LED_DISPLAY_VALUE),
        .GENERATE_START_PULSE (GENERATE_START_PULSE),
        .RESULT_READY         (RESULT_READY),
        .FRAME_ERROR          (FRAME_ERROR),
        .OVERRUN              (OVERRUN)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    int frame_q[$];
    bit m_discard;
    bit m_pending;
    int m_pval;
    int m_since;
    int e_led;
    bit e_start, e_ready, e_ferr, e_ovr;

    // Observation counters
    int cyc, ready_cnt, ferr_cnt, ovr_cnt, last_ready;
    int fr[20];

    task automatic model_reset();
        frame_q.delete();
        m_discard = 0;
        m_pending = 0;
        m_pval    = 0;
        m_since   = GAP;
        e_led     = 0;
        e_start   = 0;
        e_ready   = 0;
        e_ferr    = 0;
        e_ovr     = 0;
    endtask

    function automatic int frame_value(input bit mode);
        int bi = 0;
        for (int i = 1; i < frame_q.size(); i++)
            if (frame_q[i] > frame_q[bi]) bi = i;
        if (!mode) return bi;
        if (frame_q[bi] < 0) return 0;
        if (frame_q[bi] > 255) return 255;
        return frame_q[bi];
    endfunction

    task automatic model_step(input bit v, input int s, input bit l, input bit m);
        bit done = 0;
        bit publish;
        int val = 0;
        e_ready = 0;
        e_ferr  = 0;
        e_ovr   = 0;
        if (v) begin
            if (m_discard) begin
                if (l) m_discard = 0;
            end else begin
                frame_q.push_back(s);
                if (l && frame_q.size() == N) begin
                    done = 1;
                    val  = frame_value(m);
                    frame_q.delete();
                end else if (l) begin
                    e_ferr = 1;
                    frame_q.delete();
                end else if (frame_q.size() == N) begin
                    e_ferr    = 1;
                    m_discard = 1;
                    frame_q.delete();
                end
            end
        end
        // Cycles elapsed since the last update, counting the one this edge closes
        m_since = (m_since >= GAP) ? GAP : m_since + 1;
        publish = m_pending && (m_since >= GAP);
        if (publish) begin
            e_led   = m_pval;
            e_start = !e_start;
            e_ready = 1;
            m_since = 0;
        end
        if (done) begin
            e_ovr     = m_pending && !publish;
            m_pending = 1;
            m_pval    = val;
        end else if (publish) begin
            m_pending = 0;
        end
    endtask

    task automatic step(input bit v, input int s, input bit l, input bit m);
        SCORE_VALID  = v;
        SCORE        = SW'(s);
        SCORE_LAST   = l;
        DISPLAY_MODE = m;
        @(posedge CLK);
        model_step(v, s, l, m);
        @(negedge CLK);
        cyc++;
        chk("led", 32'(LED_DISPLAY_VALUE), 32'(e_led));
        chk("start", 32'(GENERATE_START_PULSE), 32'(e_start));
        chk("ready", 32'(RESULT_READY), 32'(e_ready));
        chk("frame_error", 32'(FRAME_ERROR), 32'(e_ferr));
        chk("overrun", 32'(OVERRUN), 32'(e_ovr));
        if (RESULT_READY === 1'b1) begin
            ready_cnt++;
            last_ready = cyc;
        end
        if (FRAME_ERROR === 1'b1) ferr_cnt++;
        if (OVERRUN === 1'b1) ovr_cnt++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(0, int'($urandom_range(0, 65535)) - 32768, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
    endtask

    task automatic send_frame(input int len, input bit mode);
        for (int i = 0; i < len; i++) step(1, fr[i], i == len - 1, mode);
    endtask

    task automatic wait_ready(input int budget);
        int start_cnt = ready_cnt;
        int k = 0;
        while (ready_cnt == start_cnt && k < budget) begin
            idle(1);
            k++;
        end
        if (ready_cnt == start_cnt) chk("wait_ready_timeout", 0, 1);
    endtask

    task automatic async_reset();
        #2;
        RESET_N     = 1'b0;
        SCORE_VALID = 1'b0;
        #1;
        chk("rst_led", 32'(LED_DISPLAY_VALUE), 0);
        chk("rst_start", 32'(GENERATE_START_PULSE), 0);
        chk("rst_ready", 32'(RESULT_READY), 0);
        chk("rst_ferr", 32'(FRAME_ERROR), 0);
        chk("rst_ovr", 32'(OVERRUN), 0);
        @(posedge CLK);
        @(negedge CLK);
        RESET_N = 1'b1;
        model_reset();
    endtask

    task automatic load_ref_frame();
        int ref_scores[10] = '{5, 9, -3, 9, 2, 1, 0, 0, 0, 7};
        for (int i = 0; i < 10; i++) fr[i] = ref_scores[i];
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int t1, t2, r0, f0, o0;
        RESET_N      = 1'b0;
        SCORE_VALID  = 1'b0;
        SCORE        = '0;
        SCORE_LAST   = 1'b0;
        DISPLAY_MODE = 1'b0;
        model_reset();
        repeat (2) @(negedge CLK);
        chk("init_led", 32'(LED_DISPLAY_VALUE), 0);
        chk("init_start", 32'(GENERATE_START_PULSE), 0);
        chk("init_ready", 32'(RESULT_READY), 0);
        chk("init_ferr", 32'(FRAME_ERROR), 0);
        chk("init_ovr", 32'(OVERRUN), 0);
        RESET_N = 1'b1;

        // Reference frame, class index, one-cycle latency after LAST
        load_ref_frame();
        send_frame(10, 0);
        chk("r33_not_yet", 32'(RESULT_READY), 0);
        idle(1);
        chk("r33_led", 32'(LED_DISPLAY_VALUE), 1);
        chk("r33_start", 32'(GENERATE_START_PULSE), 1);
        chk("r33_ready", 32'(RESULT_READY), 1);
        idle(1);
        chk("r33_ready_drop", 32'(RESULT_READY), 0);

        // Confidence saturation high and low
        load_ref_frame();
        fr[1] = 300;
        send_frame(10, 1);
        wait_ready(64);
        chk("r34_sat255", 32'(LED_DISPLAY_VALUE), 255);
        for (int i = 0; i < 10; i++) fr[i] = -5 - i;
        send_frame(10, 1);
        wait_ready(64);
        chk("r34_sat0", 32'(LED_DISPLAY_VALUE), 0);

        // Short frame and long frame, then recovery
        idle(40);
        r0 = ready_cnt;
        load_ref_frame();
        send_frame(5, 0);
        chk("r36_short_ferr", 32'(FRAME_ERROR), 1);
        idle(40);
        chk("r36_short_no_update", 32'(ready_cnt - r0), 0);
        f0 = ferr_cnt;
        for (int i = 0; i < 11; i++) fr[i] = i;
        send_frame(11, 0);
        idle(40);
        chk("r36_long_one_ferr", 32'(ferr_cnt - f0), 1);
        chk("r36_long_no_update", 32'(ready_cnt - r0), 0);
        load_ref_frame();
        send_frame(10, 0);
        wait_ready(64);
        chk("r36_recover_led", 32'(LED_DISPLAY_VALUE), 1);

        // Rate limiting and overrun
        idle(40);
        load_ref_frame();
        send_frame(10, 0);
        wait_ready(4);
        t1 = last_ready;
        idle(5);
        o0 = ovr_cnt;
        send_frame(10, 0);
        fr = '{1, 2, 3, 4, 5, 6, 7, 50, 8, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        send_frame(10, 0);
        wait_ready(64);
        t2 = last_ready;
        chk("r35_spacing", 32'(t2 - t1), 32);
        chk("r35_third_led", 32'(LED_DISPLAY_VALUE), 7);
        chk("r35_overrun", 32'(ovr_cnt - o0), 1);

        // Reset in the middle of a frame, then a clean frame
        idle(40);
        load_ref_frame();
        for (int i = 0; i < 6; i++) step(1, fr[i], 0, 0);
        async_reset();
        send_frame(10, 0);
        idle(1);
        chk("r37_led", 32'(LED_DISPLAY_VALUE), 1);
        chk("r37_ready", 32'(RESULT_READY), 1);

        // Randomized frames: lengths, idle gaps, modes, score ranges, resets
        for (int f = 0; f < 250; f++) begin
            int len = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, N + 3)) : N;
            int kind = $urandom_range(0, 2);
            int rst_at = ($urandom_range(0, 49) == 0) ? int'($urandom_range(0, len - 1)) : -1;
            bit reset_done = 0;
            for (int i = 0; i < len; i++) begin
                case (kind)
                    0:       fr[i] = int'($urandom_range(0, 3));
                    1:       fr[i] = int'($urandom_range(0, 700)) - 350;
                    default: fr[i] = int'($urandom_range(0, 65535)) - 32768;
                endcase
            end
            for (int i = 0; i < len && !reset_done; i++) begin
                if (i == rst_at) begin
                    async_reset();
                    reset_done = 1;
                end else begin
                    if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
                    step(1, fr[i], i == len - 1, 1'($urandom_range(0, 1)));
                end
            end
            idle(int'($urandom_range(0, 40)));
        end
        idle(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
